// File: rtl/alu_resp_unit_if.sv
// Request/response bundle for alu_resp_unit.
// master: drives req_valid/req_op/req_rs1/req_rs2/resp_ready and observes the rest.
// slave : the ALU responder; drives req_ready and the resp_* payload.
interface alu_resp_unit_if #(
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DWIDTH-1:0] req_rs1;
  logic [DWIDTH-1:0] req_rs2;
  logic              resp_valid;
  logic              resp_ready;
  logic [DWIDTH-1:0] resp_rd;
  logic              resp_zero;
  logic              resp_overflow;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, resp_ready,
    input  req_ready, resp_valid, resp_rd, resp_zero, resp_overflow
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, resp_ready,
    output req_ready, resp_valid, resp_rd, resp_zero, resp_overflow
  );
endinterface

// File: rtl/alu_resp_unit.sv
// Purpose: handshaked ALU responder; results queued in a 2-entry response FIFO.
// Latency: 1 cycle accept->resp_valid for logic/arith ops; shifts take shamt+2.
// Backpressure: req_ready drops when the FIFO is full (or a shift is in flight);
//   it depends only on registered state, never combinationally on resp_ready.
// Ports: clk, rst_n (async, active-low), bus (alu_resp_unit_if.slave):
//   req_valid/req_ready/req_op/req_rs1/req_rs2 request channel,
//   resp_valid/resp_ready/resp_rd/resp_zero/resp_overflow response channel.
// Build option: define ALU_SHIFT_EN to add the multi-cycle SLL/SRL/SRA path.
module alu_resp_unit #(
  parameter int DWIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_resp_unit_if.slave bus
);

  localparam int FIFO_DEPTH = 2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
`endif

  typedef struct packed {
    logic [DWIDTH-1:0] rd;
    logic              zero;
    logic              ovf;
  } resp_t;

  // Single-cycle datapath. Anything not decoded here (including the shift
  // opcodes, which never reach this path when shifting is enabled) yields
  // rd=0 / zero=1 / ovf=0.
  function automatic resp_t alu_eval(input logic [3:0]        op,
                                     input logic [DWIDTH-1:0] a,
                                     input logic [DWIDTH-1:0] b);
    resp_t             r;
    logic [DWIDTH-1:0] res;
    logic              ovf;
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        res = a + b;
        ovf = (a[DWIDTH-1] == b[DWIDTH-1]) && (res[DWIDTH-1] != a[DWIDTH-1]);
      end
      OP_SUB: begin
        res = a - b;
        ovf = (a[DWIDTH-1] != b[DWIDTH-1]) && (res[DWIDTH-1] != a[DWIDTH-1]);
      end
      // True signed compare, not the sign of a-b (which lies on overflow).
      OP_SLT: res = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOR: res = ~(a | b);
      default: res = '0;
    endcase
    r.rd   = res;
    r.zero = (res == '0);
    r.ovf  = ovf;
    return r;
  endfunction

  // Holds req_ready low while in reset and releases it on the first clock
  // after rst_n deasserts.
  logic ready_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------- FIFO state
  resp_t      mem [FIFO_DEPTH];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       fifo_full;
  logic       accept;
  logic       pop;
  logic       push_vld;
  resp_t      push_dat;

  assign fifo_full = (count == 2'd2);
  assign accept    = bus.req_valid && bus.req_ready;
  assign pop       = bus.resp_valid && bus.resp_ready;

`ifdef ALU_SHIFT_EN
  // ---------------------------------------------------------- shift sequencer
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DWIDTH-1:0] work, work_nxt;
  logic [4:0]        shcnt, shcnt_nxt;
  logic [1:0]        shop, shop_nxt;   // low opcode bits: 00 SLL, 01 SRL, 10 SRA
  logic              sh_push;
  logic              is_shift;

  assign is_shift = (bus.req_op == OP_SLL) || (bus.req_op == OP_SRL) ||
                    (bus.req_op == OP_SRA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      shcnt <= '0;
      shop  <= '0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      shcnt <= shcnt_nxt;
      shop  <= shop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    shcnt_nxt = shcnt;
    shop_nxt  = shop;
    sh_push   = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_shift) begin
          state_nxt = SHIFT;
          work_nxt  = bus.req_rs1;
          shcnt_nxt = bus.req_rs2[4:0];
          shop_nxt  = bus.req_op[1:0];
        end
      end
      SHIFT: begin
        if (shcnt != 5'd0) begin
          case (shop)
            2'b00:   work_nxt = {work[DWIDTH-2:0], 1'b0};
            2'b01:   work_nxt = {1'b0, work[DWIDTH-1:1]};
            default: work_nxt = {work[DWIDTH-1], work[DWIDTH-1:1]};
          endcase
          shcnt_nxt = shcnt - 5'd1;
        end else if (!fifo_full) begin
          // Result is held in work until the FIFO has room.
          sh_push   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready = ready_en && (state == IDLE) && !fifo_full;

  always_comb begin
    push_vld = 1'b0;
    push_dat = '0;
    if (sh_push) begin
      push_vld      = 1'b1;
      push_dat.rd   = work;
      push_dat.zero = (work == '0);
      push_dat.ovf  = 1'b0;
    end else if (accept && !is_shift) begin
      push_vld = 1'b1;
      push_dat = alu_eval(bus.req_op, bus.req_rs1, bus.req_rs2);
    end
  end
`else
  assign bus.req_ready = ready_en && !fifo_full;

  always_comb begin
    push_vld = accept;
    push_dat = alu_eval(bus.req_op, bus.req_rs1, bus.req_rs2);
  end
`endif

  // --------------------------------------------------------------- FIFO update
  // req_ready guarantees no push when full; resp_valid guarantees no pop when
  // empty. Simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_vld, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload is masked when empty so drained slots never show stale data.
  resp_t head;
  assign head              = mem[rd_ptr];
  assign bus.resp_valid    = (count != 2'd0);
  assign bus.resp_rd       = bus.resp_valid ? head.rd : '0;
  assign bus.resp_zero     = bus.resp_valid && head.zero;
  assign bus.resp_overflow = bus.resp_valid && head.ovf;

endmodule

// File: tb/tb_alu_resp_unit.sv
module tb_alu_resp_unit;

  logic clk;
  logic rst_n;

  alu_resp_unit_if #(.DWIDTH(32)) bus ();

  alu_resp_unit #(.DWIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        z;
    logic        o;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        z;
    logic        o;
  } exp_t;

  int nchecks = 0;
  int nerr    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkvec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] rd, input logic z, input logic o);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.rd = rd; v.z = z; v.o = o;
    return v;
  endfunction

  // Reference model: arithmetic done in 64-bit signed integers; overflow is
  // "the exact result does not fit in 32 signed bits".
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint r;
    logic [31:0] lo;
    sa = $signed(a);
    sb = $signed(b);
    e.rd = 32'd0;
    e.o  = 1'b0;
    case (op)
      4'b0000: e.rd = a & b;
      4'b0001: e.rd = a | b;
      4'b0010: begin r = sa + sb; lo = r[31:0]; e.rd = lo; e.o = (r != longint'($signed(lo))); end
      4'b0110: begin r = sa - sb; lo = r[31:0]; e.rd = lo; e.o = (r != longint'($signed(lo))); end
      4'b0111: e.rd = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.rd = ~(a | b);
`ifdef ALU_SHIFT_EN
      4'b1000: e.rd = a << b[4:0];
      4'b1001: e.rd = a >> b[4:0];
      4'b1010: e.rd = 32'($signed(a) >>> b[4:0]);
`endif
      default: e.rd = 32'd0;
    endcase
    e.z = (e.rd == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
  endtask

  vec_t vecs[$];
  exp_t q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", nchecks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic holding;
    logic acc;
    logic pop;
    logic seen;
    exp_t e;

    bus.req_valid  = 1'b0;
    bus.req_op     = 4'd0;
    bus.req_rs1    = 32'd0;
    bus.req_rs2    = 32'd0;
    bus.resp_ready = 1'b0;
    rst_n          = 1'b1;
    #1 rst_n = 1'b0;

    // ---------------- reset state
    repeat (3) tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rd", bus.resp_rd, 0);
    check("rst_resp_zero", bus.resp_zero, 0);
    check("rst_resp_ovf", bus.resp_overflow, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rel_req_ready", bus.req_ready, 1);
    check("rel_resp_valid", bus.resp_valid, 0);

    // ---------------- table-driven single-cycle ops, back-to-back
    vecs.push_back(mkvec(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1));
    vecs.push_back(mkvec(4'b0110, 32'd5,         32'd5,         32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0));
    vecs.push_back(mkvec(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0));
    vecs.push_back(mkvec(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0));
    vecs.push_back(mkvec(4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0));
    vecs.push_back(mkvec(4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0));
    vecs.push_back(mkvec(4'b1100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1));
    vecs.push_back(mkvec(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1));
    vecs.push_back(mkvec(4'b0110, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 0, 1));
    vecs.push_back(mkvec(4'b0110, 32'd3,         32'd5,         32'hFFFF_FFFE, 0, 0));
    vecs.push_back(mkvec(4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0));
`ifndef ALU_SHIFT_EN
    vecs.push_back(mkvec(4'b1000, 32'h0000_0001, 32'h0000_0004, 32'h0000_0000, 1, 0));
    vecs.push_back(mkvec(4'b1010, 32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 1, 0));
`endif

    bus.resp_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      check("tbl_req_ready", bus.req_ready, 1);
      tick();
      check("tbl_valid", bus.resp_valid, 1);
      check("tbl_rd", bus.resp_rd, vecs[i].rd);
      check("tbl_zero", bus.resp_zero, vecs[i].z);
      check("tbl_ovf", bus.resp_overflow, vecs[i].o);
    end
    bus.req_valid = 1'b0;
    tick();
    check("tbl_drained", bus.resp_valid, 0);

    // ---------------- backpressure: FIFO fills, third request held
    bus.resp_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd1);
    tick();
    check("bp_valid1", bus.resp_valid, 1);
    check("bp_rd_first", bus.resp_rd, 32'd2);
    drive(4'b0010, 32'd2, 32'd2);
    tick();
    check("bp_full_ready", bus.req_ready, 0);
    drive(4'b0010, 32'd3, 32'd3);
    tick();
    check("bp_held_ready", bus.req_ready, 0);
    check("bp_stable_rd", bus.resp_rd, 32'd2);
    bus.resp_ready = 1'b1;
    tick();
    check("bp_ready_back", bus.req_ready, 1);
    check("bp_rd_second", bus.resp_rd, 32'd4);
    tick();
    bus.req_valid = 1'b0;
    check("bp_rd_third", bus.resp_rd, 32'd6);
    check("bp_valid3", bus.resp_valid, 1);
    tick();
    check("bp_empty", bus.resp_valid, 0);

`ifdef ALU_SHIFT_EN
    // ---------------- SRA by 4: five cycles of req_ready low
    drive(4'b1010, 32'h8000_0000, 32'd4);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("sra_busy_ready", bus.req_ready, 0);
      check("sra_busy_valid", bus.resp_valid, 0);
      tick();
    end
    check("sra_ready_back", bus.req_ready, 1);
    check("sra_valid", bus.resp_valid, 1);
    check("sra_rd", bus.resp_rd, 32'hF800_0000);
    check("sra_zero", bus.resp_zero, 0);
    check("sra_ovf", bus.resp_overflow, 0);
    tick();
    // ---------------- SLL by 0: two cycles accept->resp_valid
    drive(4'b1000, 32'h1, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    check("sll0_not_yet", bus.resp_valid, 0);
    tick();
    check("sll0_valid", bus.resp_valid, 1);
    check("sll0_rd", bus.resp_rd, 32'h1);
    tick();
`endif

    // ---------------- randomized traffic against the model
    holding = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (!holding) begin
        if ($urandom_range(0, 3) != 0) begin
          drive(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
          holding = 1'b1;
        end else begin
          bus.req_valid = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 2) != 0);
`ifndef ALU_SHIFT_EN
      check("rnd_valid", bus.resp_valid, (q.size() != 0));
      check("rnd_ready", bus.req_ready, (q.size() < 2));
`endif
      acc = bus.req_valid && bus.req_ready;
      pop = bus.resp_valid && bus.resp_ready;
      if (bus.resp_valid) check("rnd_valid_has_exp", (q.size() != 0), 1);
      if (pop && q.size() != 0) begin
        e = q.pop_front();
        check("rnd_rd", bus.resp_rd, e.rd);
        check("rnd_zero", bus.resp_zero, e.z);
        check("rnd_ovf", bus.resp_overflow, e.o);
      end
      if (acc) q.push_back(model(bus.req_op, bus.req_rs1, bus.req_rs2));
      tick();
      if (acc) holding = 1'b0;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 80 && q.size() != 0; c++) begin
      if (bus.resp_valid) begin
        e = q.pop_front();
        check("drain_rd", bus.resp_rd, e.rd);
        check("drain_zero", bus.resp_zero, e.z);
        check("drain_ovf", bus.resp_overflow, e.o);
      end
      tick();
    end
    check("drain_model_empty", q.size(), 0);
    check("drain_dut_empty", bus.resp_valid, 0);

    // ---------------- reset with a non-empty FIFO
    bus.resp_ready = 1'b0;
    drive(4'b0010, 32'd1, 32'd2);
    tick();
    drive(4'b0001, 32'd8, 32'd1);
    tick();
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.resp_valid, 0);
    check("mid_rst_ready", bus.req_ready, 0);
    check("mid_rst_rd", bus.resp_rd, 0);
    tick();
    check("mid_rst_ready_hold", bus.req_ready, 0);
    #3 rst_n = 1'b1;
    tick();
    check("mid_rel_ready", bus.req_ready, 1);
    bus.resp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (bus.resp_valid) seen = 1'b1;
      tick();
    end
    check("mid_no_stale", seen, 0);

`ifdef ALU_SHIFT_EN
    // ---------------- reset during the third SHIFT cycle of SLL by 31
    drive(4'b1000, 32'h1, 32'd31);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("sh_rst_valid", bus.resp_valid, 0);
    check("sh_rst_ready", bus.req_ready, 0);
    tick();
    check("sh_rst_ready_hold", bus.req_ready, 0);
    #3 rst_n = 1'b1;
    tick();
    check("sh_rel_ready", bus.req_ready, 1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.resp_valid) seen = 1'b1;
      tick();
    end
    check("sh_no_stale", seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
